// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - data-priority arbiter sharing one sram-like master port between inst and data buses
module sram_like_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok
);

    typedef enum logic [2:0] {IDLE, ADDR_I, ADDR_D, DATA_I, DATA_D} state_t;

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, next_state;
    logic [CNT_W-1:0] starve_cnt, next_cnt;
    logic             starved, pick_d, arb;

    assign inst_rdata = m_rdata;
    assign data_rdata = m_rdata;

    assign starved = inst_req && (STARVE_LIMIT != 0) && (starve_cnt >= LIMIT);
    assign pick_d  = data_req && !starved;
    // Arbitrate when idle, or in the very cycle the current transaction completes.
    assign arb     = (state == IDLE) || (((state == DATA_I) || (state == DATA_D)) && m_data_ok);

    always_comb begin
        next_state   = state;
        next_cnt     = starve_cnt;
        m_req        = 1'b0;
        m_wr         = 1'b0;
        m_size       = 2'b00;
        m_addr       = 32'h0;
        m_wdata      = 32'h0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        case (state)
            ADDR_I: begin
                if (inst_req) begin
                    m_req        = 1'b1;
                    m_wr         = inst_wr;
                    m_size       = inst_size;
                    m_addr       = inst_addr;
                    m_wdata      = inst_wdata;
                    inst_addr_ok = m_addr_ok;
                    if (m_addr_ok) next_state = DATA_I;
                end else begin
                    next_state = IDLE;
                end
            end
            ADDR_D: begin
                if (data_req) begin
                    m_req        = 1'b1;
                    m_wr         = data_wr;
                    m_size       = data_size;
                    m_addr       = data_addr;
                    m_wdata      = data_wdata;
                    data_addr_ok = m_addr_ok;
                    if (m_addr_ok) next_state = DATA_D;
                end else begin
                    next_state = IDLE;
                end
            end
            DATA_I:  inst_data_ok = m_data_ok;
            DATA_D:  data_data_ok = m_data_ok;
            default: ;
        endcase
        if (arb) begin
            if (pick_d) begin
                next_state = ADDR_D;
                if (!inst_req)
                    next_cnt = '0;
                else if (starve_cnt != CNT_MAX)
                    next_cnt = starve_cnt + 1'b1;
            end else if (inst_req) begin
                next_state = ADDR_I;
                next_cnt   = '0;
            end else begin
                next_state = IDLE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= next_state;
            starve_cnt <= next_cnt;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - table-driven and scoreboard bench for sram_like_arbiter
module tb_sram_like_arbiter;

    localparam logic [31:0] I_ADDR  = 32'hBFC00000;
    localparam logic [31:0] I_WDATA = 32'h00001111;
    localparam logic [1:0]  I_SIZE  = 2'b10;
    localparam logic [31:0] D_ADDR  = 32'h80001000;
    localparam logic [31:0] D_WDATA = 32'hDEADBEEF;
    localparam logic [1:0]  D_SIZE  = 2'b01;

    logic        clock, reset;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        m_req, m_wr, m_addr_ok, m_data_ok;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;

    sram_like_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clock(clock), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        ireq, dreq, dwr, aok, dok;
        logic [31:0] rd;
        logic [1:0]  g;
        logic        iaok, daok, idok, ddok;
    } vec_t;

    vec_t       vt[18];
    logic [1:0] sbq[$];
    int         checks = 0;
    int         fails  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] exp_out(input logic [1:0] g, input logic dwr,
                                            input logic iaok, input logic daok,
                                            input logic idok, input logic ddok);
        logic [67:0] m;
        m = '0;
        if (g == 2'd1) m = {1'b1, 1'b0, I_SIZE, I_ADDR, I_WDATA};
        else if (g == 2'd2) m = {1'b1, dwr, D_SIZE, D_ADDR, D_WDATA};
        return {m, iaok, daok, idok, ddok};
    endfunction

    function automatic logic [71:0] dut_out();
        return {m_req, m_wr, m_size, m_addr, m_wdata,
                inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};
    endfunction

    task automatic sb_dok();
        logic [1:0] s;
        if (inst_data_ok || data_data_ok) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 128'(1), 128'(0));
            end else begin
                s = sbq.pop_front();
                chk("sb_side", 128'({inst_data_ok, data_data_ok}),
                    128'((s == 2'd1) ? 2'b10 : 2'b01));
                chk("sb_rdata", 128'((s == 2'd1) ? inst_rdata : data_rdata), 128'(m_rdata));
            end
        end
    endtask

    task automatic drive(input logic ireq, input logic dreq, input logic dwr,
                         input logic aok, input logic dok, input logic [31:0] rd);
        inst_req  = ireq;
        data_req  = dreq;
        data_wr   = dwr;
        m_addr_ok = aok;
        m_data_ok = dok;
        m_rdata   = rd;
    endtask

    initial begin
        int  grants, cyc;
        logic pend, exp_i;

        //            ireq dreq dwr aok dok rd            g  iaok daok idok ddok
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3C1D0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0BADF00D, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55AA55AA, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};

        inst_wr    = 1'b0;
        inst_size  = I_SIZE;
        inst_addr  = I_ADDR;
        inst_wdata = I_WDATA;
        data_size  = D_SIZE;
        data_addr  = D_ADDR;
        data_wdata = D_WDATA;
        reset      = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h13572468);
        #3;
        chk("reset_outputs", 128'(dut_out()), 128'(0));
        chk("reset_rdata", 128'({inst_rdata, data_rdata}), 128'({32'h13572468, 32'h13572468}));
        @(negedge clock);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            drive(vt[i].ireq, vt[i].dreq, vt[i].dwr, vt[i].aok, vt[i].dok, vt[i].rd);
            #1;
            chk($sformatf("vec%0d_out", i), 128'(dut_out()),
                128'(exp_out(vt[i].g, vt[i].dwr, vt[i].iaok, vt[i].daok, vt[i].idok, vt[i].ddok)));
            chk($sformatf("vec%0d_rdata", i), 128'({inst_rdata, data_rdata}),
                128'({vt[i].rd, vt[i].rd}));
            sb_dok();
            if (vt[i].aok && (vt[i].iaok || vt[i].daok))
                sbq.push_back(vt[i].iaok ? 2'd1 : 2'd2);
        end

        // Both sides hammering: expect D,D,D,D,I repeating, so the counter restarts after each I.
        grants = 0;
        pend   = 1'b0;
        cyc    = 0;
        while (cyc < 200 && (grants < 10 || pend)) begin
            @(negedge clock);
            cyc++;
            drive(grants < 10, grants < 10, 1'b0, 1'b0, pend, $urandom);
            #1;
            if (pend) begin
                chk("starve_dok", 128'(inst_data_ok | data_data_ok), 128'(1));
                sb_dok();
                pend = 1'b0;
            end
            if (m_req) begin
                exp_i = ((grants % 5) == 4);
                chk($sformatf("starve_grant%0d", grants), 128'(m_addr),
                    128'(exp_i ? I_ADDR : D_ADDR));
                m_addr_ok = 1'b1;
                #1;
                chk("starve_aok", 128'({inst_addr_ok, data_addr_ok}),
                    128'(exp_i ? 2'b10 : 2'b01));
                sbq.push_back(exp_i ? 2'd1 : 2'd2);
                grants++;
                pend = 1'b1;
            end
        end
        chk("starve_grants", 128'(grants), 128'(10));

        // Asynchronous reset while an inst transaction waits for its data.
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        chk("rst_pre_aok", 128'(inst_addr_ok), 128'(1));
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        reset = 1'b1;
        m_data_ok = 1'b1;
        m_rdata   = 32'hA5A50001;
        #1;
        chk("rst_mid_outputs", 128'(dut_out()), 128'(0));
        chk("rst_mid_rdata", 128'({inst_rdata, data_rdata}), 128'({32'hA5A50001, 32'hA5A50001}));
        @(negedge clock);
        #1;
        chk("rst_hold_outputs", 128'(dut_out()), 128'(0));
        reset = 1'b0;
        @(negedge clock);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("rst_post_idle", 128'(dut_out()), 128'(0));
        @(negedge clock);
        #1;
        chk("rst_post_dgrant", 128'(dut_out()), 128'(exp_out(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));

        chk("sb_empty", 128'(sbq.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
